// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and helpers for the DFF-bank arbiter: slot state encoding and
// a constant clog2 used to size requester indices.
package dff_bank_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester/downstream bundle for dff_bank_arbiter. The lock vector exists only
// when DFF_BANK_ARBITER_LOCK_EN is defined.
interface dff_bank_arbiter_if
    import dff_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) ();
    localparam int IDW = clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      q;
    logic [IDW-1:0]     q_src;
    logic               q_vld;
    logic               q_rdy;
`ifdef DFF_BANK_ARBITER_LOCK_EN
    logic [NREQ-1:0]    lock;

    modport master (output req, wdata, q_rdy, lock, input gnt, q, q_src, q_vld);
    modport slave  (input req, wdata, q_rdy, lock, output gnt, q, q_src, q_vld);
`else
    modport master (output req, wdata, q_rdy, input gnt, q, q_src, q_vld);
    modport slave  (input req, wdata, q_rdy, output gnt, q, q_src, q_vld);
`endif

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_elig searching from
// i_ptr upward with wrap-around.
module rr_pick
    import dff_bank_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IDW-1:0]  i_ptr,
    output logic [IDW-1:0]  o_win,
    output logic            o_any
);

    logic [IDW-1:0] w_idx;

    // Walk the search order backwards so the earliest eligible index is written last.
    always_comb begin
        o_win = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(i_ptr) + k) % NREQ);
            o_win = i_elig[w_idx] ? w_idx : o_win;
            o_any = o_any | i_elig[w_idx];
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter capturing one requester's word per cycle into a shared
// valid/ready output slot. Optional priority lock: DFF_BANK_ARBITER_LOCK_EN.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic             clk,
    input  logic             rest,
    dff_bank_arbiter_if.slave bus
);
    localparam int IDW = clog2(NREQ);

    state_t          r_state;
    logic [DW-1:0]   r_q;
    logic [IDW-1:0]  r_src;
    logic            r_vld;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_ptr;

    logic [NREQ-1:0] w_elig;
    logic [IDW-1:0]  w_win;
    logic            w_any;
    logic            w_free;
    logic [DW-1:0]   w_sel;
    logic [IDW-1:0]  w_ptr_nxt;

    // A requester granted this cycle has not yet dropped req, so mask it out.
    assign w_elig = bus.req & ~r_gnt;
    assign w_free = (r_state == EMPTY) || bus.q_rdy;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    // Data mux for the winning requester's word.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel = (w_win == IDW'(i)) ? bus.wdata[i*DW +: DW] : w_sel;
        end
    end

    // Next search start: just past the winner, or the winner itself when locked.
    always_comb begin
        w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
`ifdef DFF_BANK_ARBITER_LOCK_EN
        if (bus.lock[w_win]) begin
            w_ptr_nxt = w_win;
        end else begin
            w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
        end
`endif
    end

    // Slot FSM: capture when free and something is eligible, drain otherwise, hold on stall.
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_state <= EMPTY;
            r_q     <= '0;
            r_src   <= '0;
            r_vld   <= 1'b0;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                EMPTY, FULL: begin
                    if (w_free && w_any) begin
                        r_state <= FULL;
                        r_q     <= w_sel;
                        r_src   <= w_win;
                        r_vld   <= 1'b1;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_ptr   <= w_ptr_nxt;
                    end else if (w_free) begin
                        r_state <= EMPTY;
                        r_vld   <= 1'b0;
                        r_gnt   <= '0;
                    end else begin
                        r_gnt   <= '0;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_vld   <= 1'b0;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.q     = r_q;
    assign bus.q_src = r_src;
    assign bus.q_vld = r_vld;
    assign bus.gnt   = r_gnt;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (NREQ=4, DW=8); lock-dependent expectations
// follow DFF_BANK_ARBITER_LOCK_EN.
module tb_dff_bank_arbiter;
    import dff_bank_pkg::*;

    logic clk;
    logic rest;
    int   n_checks;
    int   n_errors;

`ifdef DFF_BANK_ARBITER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    dff_bank_arbiter_if #(.NREQ(4), .DW(8)) bus ();

    dff_bank_arbiter #(.NREQ(4), .DW(8)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_errors = n_errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic vld, input logic [7:0] q,
                              input logic [1:0] src, input logic [3:0] gnt);
        check({tag, ".vld"}, 32'(bus.q_vld), 32'(vld));
        check({tag, ".q"},   32'(bus.q),     32'(q));
        check({tag, ".src"}, 32'(bus.q_src), 32'(src));
        check({tag, ".gnt"}, 32'(bus.gnt),   32'(gnt));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rest      = 1'b0;
        bus.req   = 4'b1111;
        bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.q_rdy = 1'b1;
`ifdef DFF_BANK_ARBITER_LOCK_EN
        bus.lock  = 4'b0000;
`endif
        tick();
        tick();
        check_slot("reset", 1'b0, 8'h00, 2'd0, 4'b0000);

        // Round-robin with every requester pending
        rest = 1'b1;
        tick(); check_slot("rr0", 1'b1, 8'h11, 2'd0, 4'b0001);
        tick(); check_slot("rr1", 1'b1, 8'h22, 2'd1, 4'b0010);
        tick(); check_slot("rr2", 1'b1, 8'h33, 2'd2, 4'b0100);
        tick(); check_slot("rr3", 1'b1, 8'h44, 2'd3, 4'b1000);
        tick(); check_slot("rr4", 1'b1, 8'h11, 2'd0, 4'b0001);
        tick(); check_slot("rr5", 1'b1, 8'h22, 2'd1, 4'b0010);
        tick(); check_slot("rr6", 1'b1, 8'h33, 2'd2, 4'b0100);

        // Stall with q_src=2 held for three cycles
        bus.q_rdy = 1'b0;
        bus.req   = 4'b1010;
        tick(); check_slot("stall0", 1'b1, 8'h33, 2'd2, 4'b0000);
        tick(); check_slot("stall1", 1'b1, 8'h33, 2'd2, 4'b0000);
        tick(); check_slot("stall2", 1'b1, 8'h33, 2'd2, 4'b0000);
        bus.q_rdy = 1'b1;
        tick(); check_slot("unstall", 1'b1, 8'h44, 2'd3, 4'b1000);

        // Single capture of requester 1, then drain to empty
        bus.req = 4'b0010;
        tick(); check_slot("cap1", 1'b1, 8'h22, 2'd1, 4'b0010);
        bus.req = 4'b0000;
        tick(); check_slot("drain", 1'b0, 8'h22, 2'd1, 4'b0000);
        tick(); check_slot("idle", 1'b0, 8'h22, 2'd1, 4'b0000);

        // Capture requester 2 (ptr -> 3), stall, then reset mid-operation
        bus.req = 4'b0100;
        tick(); check_slot("cap2", 1'b1, 8'h33, 2'd2, 4'b0100);
        bus.req   = 4'b0000;
        bus.q_rdy = 1'b0;
        tick(); check_slot("hold2", 1'b1, 8'h33, 2'd2, 4'b0000);
        rest = 1'b0;
        tick(); check_slot("midrst", 1'b0, 8'h00, 2'd0, 4'b0000);
        rest      = 1'b1;
        bus.req   = 4'b1010;
        bus.q_rdy = 1'b1;
        tick(); check_slot("postrst0", 1'b1, 8'h22, 2'd1, 4'b0010);
        tick(); check_slot("postrst1", 1'b1, 8'h44, 2'd3, 4'b1000);

        // Two requesters alternate because of the grant mask
        bus.req = 4'b0011;
        tick(); check_slot("alt0", 1'b1, 8'h11, 2'd0, 4'b0001);
        tick(); check_slot("alt1", 1'b1, 8'h22, 2'd1, 4'b0010);
        tick(); check_slot("alt2", 1'b1, 8'h11, 2'd0, 4'b0001);
        tick(); check_slot("alt3", 1'b1, 8'h22, 2'd1, 4'b0010);

        bus.req = 4'b0111;
        tick(); check_slot("tri0", 1'b1, 8'h33, 2'd2, 4'b0100);
        tick(); check_slot("tri1", 1'b1, 8'h11, 2'd0, 4'b0001);
        tick(); check_slot("tri2", 1'b1, 8'h22, 2'd1, 4'b0010);
        tick(); check_slot("tri3", 1'b1, 8'h33, 2'd2, 4'b0100);

        // Lock on requester 0 keeps ptr at 0 across a stall
        bus.req = 4'b0011;
`ifdef DFF_BANK_ARBITER_LOCK_EN
        bus.lock = 4'b0001;
`endif
        tick(); check_slot("lk0", 1'b1, 8'h11, 2'd0, 4'b0001);
        bus.q_rdy = 1'b0;
        tick(); check_slot("lkstall", 1'b1, 8'h11, 2'd0, 4'b0000);
        bus.q_rdy = 1'b1;
        tick();
        if (LOCK) begin
            check_slot("lk1", 1'b1, 8'h11, 2'd0, 4'b0001);
        end else begin
            check_slot("lk1", 1'b1, 8'h22, 2'd1, 4'b0010);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
